// File: rtl/spi_host_master_if.sv
// Command-side bundle of the SUMP SPI host master: one 40-bit command in,
// one assembled response word out.
interface spi_host_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [39:0] cmd;
  logic [2:0]  rx_count;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        busy;

  modport master (
    output cmd_valid, cmd, rx_count,
    input  cmd_ready, rx_data, rx_valid, busy
  );

  modport slave (
    input  cmd_valid, cmd, rx_count,
    output cmd_ready, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/spi_host_master.sv
// SPI mode-0 master for the SUMP command link: shifts out an opcode (plus four
// opdata bytes for long commands), then clocks in up to four response bytes.
module spi_host_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int BYTE_GAP = 4,
  parameter int CS_HOLD  = 2
) (
  input  logic               clock,
  input  logic               extReset_n,
  spi_host_master_if.slave   host,
  output logic               cs_n,
  output logic               sclk,
  output logic               mosi,
  input  logic               miso
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_BIT_LO, ST_BIT_HI, ST_GAP, ST_HOLD, ST_DONE
  } state_t;

  localparam logic [7:0] DIV_LOAD   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LOAD = 8'(CS_SETUP - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(BYTE_GAP - 1);
  localparam logic [7:0] HOLD_LOAD  = 8'(CS_HOLD - 1);
  localparam logic [7:0] DONE_LOAD  = 8'd1;

  state_t      state_reg, state_next;
  logic [7:0]  div_cnt_reg, div_cnt_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [3:0]  byte_cnt_reg, byte_cnt_next;
  logic [39:0] cmd_reg;
  logic [3:0]  tx_bytes_reg, total_reg;
  logic [7:0]  shift_reg;
  logic [31:0] rx_data_reg;
  logic        rx_valid_reg, cs_n_reg, sclk_reg, mosi_reg, ready_reg;
  logic        mosi_next;

  logic        accept, phase_end, last_byte, sample, rx_write, tx_active;
  logic [2:0]  rx_clamped;
  logic [3:0]  tx_bytes_new, rx_slot;
  logic [7:0]  cur_tx;
  logic [7:0]  tx_byte [0:4];

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_tx_byte
      assign tx_byte[gi] = cmd_reg[gi*8 +: 8];
    end
  endgenerate

  assign accept       = host.cmd_valid && ready_reg;
  assign phase_end    = (div_cnt_reg == 8'd0);
  assign last_byte    = ((byte_cnt_reg + 4'd1) == total_reg);
  assign rx_clamped   = (host.rx_count > 3'd4) ? 3'd4 : host.rx_count;
  assign tx_bytes_new = host.cmd[7] ? 4'd5 : 4'd1;
  // MISO is taken on the first cycle of the high phase, i.e. right after the rising edge.
  assign sample       = (state_reg == ST_BIT_HI) && (div_cnt_reg == DIV_LOAD);
  assign rx_write     = (state_reg == ST_BIT_HI) && phase_end && (bit_cnt_reg == 3'd7)
                        && (byte_cnt_reg >= tx_bytes_reg);
  assign rx_slot      = byte_cnt_reg - tx_bytes_reg;
  assign tx_active    = (byte_cnt_next < tx_bytes_reg);

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next    = ST_SETUP;
          bit_cnt_next  = 3'd0;
          byte_cnt_next = 4'd0;
        end
      end
      ST_SETUP:  if (phase_end) state_next = ST_BIT_LO;
      ST_BIT_LO: if (phase_end) state_next = ST_BIT_HI;
      ST_BIT_HI: begin
        if (phase_end) begin
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg != 3'd7) begin
            state_next = ST_BIT_LO;
          end else begin
            byte_cnt_next = byte_cnt_reg + 4'd1;
            state_next    = last_byte ? ST_HOLD : ST_GAP;
          end
        end
      end
      ST_GAP:  if (phase_end) state_next = ST_BIT_LO;
      ST_HOLD: if (phase_end) state_next = ST_DONE;
      ST_DONE: if (phase_end) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Every phase change reloads the divider with the length of the phase being entered.
  always_comb begin
    div_cnt_next = phase_end ? 8'd0 : div_cnt_reg - 8'd1;
    if (state_next != state_reg) begin
      case (state_next)
        ST_SETUP:            div_cnt_next = SETUP_LOAD;
        ST_BIT_LO, ST_BIT_HI: div_cnt_next = DIV_LOAD;
        ST_GAP:              div_cnt_next = GAP_LOAD;
        ST_HOLD:             div_cnt_next = HOLD_LOAD;
        ST_DONE:             div_cnt_next = DONE_LOAD;
        default:             div_cnt_next = 8'd0;
      endcase
    end
  end

  always_comb begin
    cur_tx = 8'h00;
    for (int i = 0; i < 5; i++) begin
      if (byte_cnt_next == 4'(i)) cur_tx = tx_byte[i];
    end
    mosi_next = 1'b0;
    if (state_next == ST_BIT_LO && state_reg != ST_BIT_LO)
      mosi_next = tx_active ? cur_tx[~bit_cnt_next] : 1'b0;
    else if (state_next == ST_BIT_LO || state_next == ST_BIT_HI)
      mosi_next = mosi_reg;
  end

  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      state_reg    <= ST_IDLE;
      div_cnt_reg  <= 8'd0;
      bit_cnt_reg  <= 3'd0;
      byte_cnt_reg <= 4'd0;
      cmd_reg      <= 40'd0;
      tx_bytes_reg <= 4'd1;
      total_reg    <= 4'd1;
      shift_reg    <= 8'd0;
      rx_data_reg  <= 32'd0;
      rx_valid_reg <= 1'b0;
      cs_n_reg     <= 1'b1;
      sclk_reg     <= 1'b0;
      mosi_reg     <= 1'b0;
      ready_reg    <= 1'b1;
    end else begin
      state_reg    <= state_next;
      div_cnt_reg  <= div_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      cs_n_reg     <= (state_next == ST_IDLE) || (state_next == ST_DONE);
      sclk_reg     <= (state_next == ST_BIT_HI);
      mosi_reg     <= mosi_next;
      ready_reg    <= (state_next == ST_IDLE);
      rx_valid_reg <= (state_reg == ST_HOLD) && (state_next == ST_DONE);
      if (accept) begin
        cmd_reg      <= host.cmd;
        tx_bytes_reg <= tx_bytes_new;
        total_reg    <= tx_bytes_new + {1'b0, rx_clamped};
        rx_data_reg  <= 32'd0;
      end
      if (sample) shift_reg <= {shift_reg[6:0], miso};
      if (rx_write) begin
        case (rx_slot)
          4'd0:    rx_data_reg[7:0]   <= shift_reg;
          4'd1:    rx_data_reg[15:8]  <= shift_reg;
          4'd2:    rx_data_reg[23:16] <= shift_reg;
          4'd3:    rx_data_reg[31:24] <= shift_reg;
          default: ;
        endcase
      end
    end
  end

  assign host.cmd_ready = ready_reg;
  assign host.busy      = ~ready_reg;
  assign host.rx_data   = rx_data_reg;
  assign host.rx_valid  = rx_valid_reg;
  assign cs_n           = cs_n_reg;
  assign sclk           = sclk_reg;
  assign mosi           = mosi_reg;

endmodule

// File: tb/tb_spi_host_master.sv
// Bench for spi_host_master: a slot-timing model predicts every output each cycle,
// a MISO responder plays back the chosen reply, and directed cases pin literal values.
module tb_spi_host_master;
  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int BYTE_GAP = 4;
  localparam int CS_HOLD  = 2;
  localparam int BYTE_LEN = 16 * CLK_DIV;
  localparam int PERIOD   = BYTE_LEN + BYTE_GAP;

  logic clock = 1'b0;
  logic extReset_n = 1'b0;
  logic miso = 1'b0;
  logic cs_n, sclk, mosi;

  spi_host_master_if bus ();

  spi_host_master #(
    .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .BYTE_GAP(BYTE_GAP), .CS_HOLD(CS_HOLD)
  ) dut (
    .clock(clock), .extReset_n(extReset_n), .host(bus),
    .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // model of the transaction in flight (or last finished)
  bit          have_txn = 0;
  int          acc_cyc, txb, nbytes;
  logic [7:0]  txbytes [5];
  logic [7:0]  stream [9];
  logic [31:0] exp_rx = 0;
  logic [31:0] next_resp = 0;
  int          acc_count = 0, done_count = 0, dut_valid_cnt = 0;

  // raw measurements of the DUT pins
  int          meas_low = 0, meas_high = 0, meas_edges = 0;
  logic [71:0] meas_mosi = 0;
  int          snap_low, snap_high, snap_edges;
  logic [71:0] snap_mosi;
  logic [31:0] snap_rx;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no response within cycle budget (cycle %0d)", name, cyc);
  endtask

  function automatic int cs_low_len(input int n);
    return CS_SETUP + n * BYTE_LEN + (n - 1) * BYTE_GAP + CS_HOLD;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin : compare
    int rel, len, t, b, r, bi, rxn;
    bit in_slot, hi, e_cs, e_valid, e_ready, e_mosi;

    if (cs_n === 1'b0 && prev_cs === 1'b1) begin
      snap_high  = meas_high;
      meas_low   = 0;
      meas_edges = 0;
      meas_mosi  = '0;
    end
    if (cs_n === 1'b1 && prev_cs === 1'b0) meas_high = 0;
    if (cs_n === 1'b0) meas_low++;
    else meas_high++;
    if (sclk === 1'b1 && prev_sclk === 1'b0) begin
      meas_edges++;
      meas_mosi = {meas_mosi[70:0], mosi};
    end
    if (bus.rx_valid === 1'b1) dut_valid_cnt++;
    prev_cs   = cs_n;
    prev_sclk = sclk;

    if (!extReset_n) begin
      chk("reset_outputs", {cs_n, sclk, mosi, bus.cmd_ready, bus.busy, bus.rx_valid, bus.rx_data},
          {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
      have_txn = 0;
      exp_rx   = 0;
      miso     = 1'b0;
    end else begin
      e_cs = 1; e_valid = 0; e_ready = 1; in_slot = 0; hi = 0;
      b = 0; bi = 0; rel = 0; len = 0;
      if (have_txn) begin
        rel     = cyc - (acc_cyc + 1);
        len     = cs_low_len(nbytes);
        e_cs    = !(rel >= 0 && rel < len);
        e_valid = (rel == len);
        e_ready = (rel >= len + 2);
        t = rel - CS_SETUP;
        if (t >= 0 && rel < len - CS_HOLD) begin
          b = t / PERIOD;
          r = t % PERIOD;
          if (r < BYTE_LEN) begin
            in_slot = 1;
            bi = r / (2 * CLK_DIV);
            hi = (r % (2 * CLK_DIV)) >= CLK_DIV;
          end
        end
      end
      chk("cs_n", cs_n, e_cs);
      chk("sclk", sclk, in_slot && hi);
      chk("cmd_ready", bus.cmd_ready, e_ready);
      chk("busy", bus.busy, !e_ready);
      chk("rx_valid", bus.rx_valid, e_valid);
      if (in_slot) begin
        e_mosi = (b < txb) ? txbytes[b][7 - bi] : 1'b0;
        chk("mosi", mosi, e_mosi);
      end
      if (!have_txn || rel >= len) chk("rx_data", bus.rx_data, exp_rx);
      if (e_valid) begin
        done_count++;
        snap_low   = meas_low;
        snap_edges = meas_edges;
        snap_mosi  = meas_mosi;
        snap_rx    = bus.rx_data;
      end
      // slave side: present the bit of the slot currently on the wire
      if (in_slot) miso = stream[b][7 - bi];
      if (bus.cmd_valid && e_ready) begin
        have_txn = 1;
        acc_cyc  = cyc;
        acc_count++;
        txb    = bus.cmd[7] ? 5 : 1;
        rxn    = (bus.rx_count > 3'd4) ? 4 : int'(bus.rx_count);
        nbytes = txb + rxn;
        exp_rx = 0;
        for (int k = 0; k < 5; k++) txbytes[k] = bus.cmd[8*k +: 8];
        for (int k = 0; k < 9; k++) begin
          if (k >= txb && k - txb < rxn) stream[k] = next_resp[8*(k - txb) +: 8];
          else stream[k] = 8'($urandom);
        end
        for (int k = 0; k < rxn; k++) exp_rx[8*k +: 8] = next_resp[8*k +: 8];
      end
    end
  end

  task automatic issue(input logic [39:0] c, input logic [2:0] rc, input logic [31:0] resp);
    int a0;
    bit got;
    a0 = acc_count;
    got = 0;
    @(posedge clock); #1;
    next_resp = resp;
    bus.cmd = c;
    bus.rx_count = rc;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clock);
      if (acc_count != a0) got = 1;
    end
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd = {$urandom, 8'($urandom)};
    bus.rx_count = 3'($urandom);
    if (!got) timeout_fail("accept_timeout");
  endtask

  task automatic wait_done(input int d0);
    bit got;
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge clock);
      if (done_count != d0) got = 1;
    end
    if (!got) timeout_fail("done_timeout");
    @(posedge clock);
  endtask

  task automatic transact(input logic [39:0] c, input logic [2:0] rc, input logic [31:0] resp);
    int d0;
    d0 = done_count;
    issue(c, rc, resp);
    wait_done(d0);
  endtask

  initial begin
    int d0, a0, vcount;
    bit got;
    bus.cmd_valid = 1'b0;
    bus.cmd = '0;
    bus.rx_count = '0;
    repeat (3) @(posedge clock);
    #1 extReset_n = 1'b1;
    repeat (3) @(posedge clock);

    // short command
    transact(40'h00_0000_0000, 3'd0, 32'hDEADBEEF);
    chk("short_cs_low", snap_low, 68);
    chk("short_edges", snap_edges, 8);
    chk("short_mosi", snap_mosi[7:0], 8'h00);
    chk("short_rx", snap_rx, 32'h0);
    $display("short cmd: cs_low=%0d edges=%0d rx=%h", snap_low, snap_edges, snap_rx);

    // long command
    transact({32'h04030201, 8'hC0}, 3'd0, 32'h0);
    chk("long_cs_low", snap_low, 340);
    chk("long_edges", snap_edges, 40);
    chk("long_mosi", snap_mosi[39:0], 40'hC0_01_02_03_04);
    $display("long cmd: cs_low=%0d edges=%0d mosi=%h", snap_low, snap_edges, snap_mosi[39:0]);

    // ID query
    transact({32'h0, 8'h02}, 3'd4, 32'h534C4131);
    chk("id_rx", snap_rx, 32'h534C4131);
    chk("id_edges", snap_edges, 40);
    chk("id_mosi", snap_mosi[39:0], 40'h02_00_00_00_00);
    chk("id_cs_low", snap_low, 340);
    $display("id query: rx=%h edges=%0d", snap_rx, snap_edges);

    // back-to-back with cmd_valid held high; cmd scrambled while busy
    d0 = done_count;
    issue({32'hAABBCCDD, 8'h81}, 3'd1, 32'h000000E7);
    bus.cmd_valid = 1'b1;
    bus.cmd = {32'hFFFFFFFF, 8'hFF};
    bus.rx_count = 3'd3;
    repeat (20) @(posedge clock);
    #1;
    a0 = acc_count;
    next_resp = 32'h7777A55A;
    bus.cmd = {32'h01020304, 8'h11};
    bus.rx_count = 3'd2;
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clock);
      if (acc_count != a0) got = 1;
    end
    #1 bus.cmd_valid = 1'b0;
    if (!got) timeout_fail("b2b_accept_timeout");
    wait_done(d0 + 1);
    chk("b2b_cs_high", snap_high, 3);  // two DONE cycles plus the acceptance cycle
    chk("b2b_second_mosi", snap_mosi[23:16], 8'h11);
    chk("b2b_second_rx", snap_rx, 32'h0000A55A);
    $display("back-to-back: cs_high=%0d opcode=%h rx=%h", snap_high, snap_mosi[23:16], snap_rx);

    // asynchronous reset in bit 3 of byte 2 of a long command
    issue({32'h12345678, 8'hA5}, 3'd2, 32'h0000BEEF);
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clock);
      if (meas_edges >= 20) got = 1;
    end
    if (!got) timeout_fail("abort_point_timeout");
    @(negedge clock); #2;
    extReset_n = 1'b0;
    #1;
    chk("abort_immediate", {cs_n, sclk}, 2'b10);
    vcount = dut_valid_cnt;
    repeat (3) @(posedge clock);
    #1 extReset_n = 1'b1;
    repeat (600) @(posedge clock);
    chk("abort_no_rx_valid", dut_valid_cnt, vcount);
    transact({32'h0, 8'h02}, 3'd4, 32'h04030201);
    chk("post_abort_rx", snap_rx, 32'h04030201);
    $display("abort: valid_pulses=%0d post rx=%h", dut_valid_cnt - vcount, snap_rx);

    // clamp rx_count 7 to four bytes
    transact({32'hFFFFFFFF, 8'h02}, 3'd7, 32'hCAFEF00D);
    chk("clamp_rx", snap_rx, 32'hCAFEF00D);
    chk("clamp_edges", snap_edges, 40);
    $display("clamp: rx=%h edges=%0d", snap_rx, snap_edges);

    // randomized commands against the model
    for (int n = 0; n < 14; n++) begin
      logic [39:0] c;
      logic [2:0]  rc;
      logic [31:0] rs;
      c  = {$urandom, 8'($urandom)};
      rc = 3'($urandom_range(0, 7));
      rs = $urandom;
      transact(c, rc, rs);
      $display("random %0d: cmd=%h rx_count=%0d rx=%h", n, c, rc, snap_rx);
      repeat ($urandom_range(0, 5)) @(posedge clock);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget (cycle %0d)", cyc);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
